// File: rtl/aap_execute_unit.sv
// ---------------------------------------------------------------------------
// aap_execute_unit
//   Execute stage between decode and the register file / data memory.
//   Accepts one decoded instruction per cycle (operands already read).
//   ALU ops write back one cycle after accept; loads/stores run a req/ack
//   memory handshake with unbounded wait states, during which in_ready is low.
//
// Ports
//   clock, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready       instruction handshake
//   in_op/in_rd/in_a/in_b/in_imm   decoded instruction fields
//   wr_en/wr_addr/wr_data   register write-back (one-cycle strobe)
//   carry                   carry/borrow flag
//   illegal                 one-cycle pulse on accepting an unknown opcode
//   mem_req/mem_we/mem_byte/mem_addr/mem_wdata   memory request (held to ack)
//   mem_ack/mem_rdata       memory completion and load data
// ---------------------------------------------------------------------------
module aap_execute_unit #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 6,
    parameter int MEM_AW = 16,
    parameter int IMM_W  = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              carry,
    output logic              illegal,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_AND  = 6'd3,
        OP_OR   = 6'd4,  OP_XOR  = 6'd5,  OP_ASR  = 6'd6,  OP_LSL  = 6'd7,
        OP_LSR  = 6'd8,  OP_MOV  = 6'd9,  OP_ADDI = 6'd10, OP_SUBI = 6'd11,
        OP_ASRI = 6'd12, OP_LSLI = 6'd13, OP_LSRI = 6'd14, OP_MOVI = 6'd15,
        OP_LDB  = 6'd16, OP_LDW  = 6'd17, OP_STB  = 6'd18, OP_STW  = 6'd19,
        OP_ADDC = 6'd20, OP_SUBC = 6'd21
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_e;

    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    state_e              state;
    op_e                 op;
    logic [REG_AW-1:0]   ld_rd;

    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   opb;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W:0]     cin;
    logic                shift_big;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_cout;
    logic                dec_wr;
    logic                dec_mem;
    logic                dec_illegal;
    logic [DATA_W-1:0]   addr_sum;
    logic [DATA_W+MEM_AW-1:0] addr_ext;
    logic [DATA_W+IMM_W-1:0]  imm_wide;

    assign op       = op_e'(in_op);
    assign in_ready = (state == S_IDLE);

    assign imm_wide = {{DATA_W{1'b0}}, in_imm};
    assign imm_ext  = imm_wide[DATA_W-1:0];
    assign addr_sum = in_a + imm_ext;
    // Widen before slicing so any MEM_AW/DATA_W ratio yields the low MEM_AW bits.
    assign addr_ext = {{MEM_AW{1'b0}}, addr_sum};

    always_comb begin
        opb         = in_b;
        cin         = '0;
        alu_res     = '0;
        alu_cout    = carry;
        dec_wr      = 1'b0;
        dec_mem     = 1'b0;
        dec_illegal = 1'b0;

        if (in_op >= 6'd10 && in_op <= 6'd15)
            opb = imm_ext;
        if (op == OP_ADDC || op == OP_SUBC)
            cin[0] = carry;

        // One extra bit: for add it is the carry-out, for subtract the borrow.
        sum       = {1'b0, in_a} + {1'b0, opb} + cin;
        diff      = {1'b0, in_a} - {1'b0, opb} - cin;
        shift_big = (opb >= SHIFT_LIM);

        case (op)
            OP_NOP: ;
            OP_ADD, OP_ADDI, OP_ADDC: begin
                alu_res  = sum[DATA_W-1:0];
                alu_cout = sum[DATA_W];
                dec_wr   = 1'b1;
            end
            OP_SUB, OP_SUBI, OP_SUBC: begin
                alu_res  = diff[DATA_W-1:0];
                alu_cout = diff[DATA_W];
                dec_wr   = 1'b1;
            end
            OP_AND: begin alu_res = in_a & in_b; dec_wr = 1'b1; end
            OP_OR:  begin alu_res = in_a | in_b; dec_wr = 1'b1; end
            OP_XOR: begin alu_res = in_a ^ in_b; dec_wr = 1'b1; end
            OP_ASR, OP_ASRI: begin
                alu_res = shift_big ? {DATA_W{in_a[DATA_W-1]}}
                                    : DATA_W'($signed(in_a) >>> opb);
                dec_wr  = 1'b1;
            end
            OP_LSL, OP_LSLI: begin
                alu_res = shift_big ? '0 : (in_a << opb);
                dec_wr  = 1'b1;
            end
            OP_LSR, OP_LSRI: begin
                alu_res = shift_big ? '0 : (in_a >> opb);
                dec_wr  = 1'b1;
            end
            OP_MOV:  begin alu_res = in_a;    dec_wr = 1'b1; end
            OP_MOVI: begin alu_res = imm_ext; dec_wr = 1'b1; end
            OP_LDB, OP_LDW, OP_STB, OP_STW: dec_mem = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            carry     <= 1'b0;
            illegal   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_rd     <= '0;
        end else begin
            wr_en   <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        carry <= alu_cout;
                        if (dec_mem) begin
                            state     <= S_MEM;
                            mem_req   <= 1'b1;
                            mem_we    <= (op == OP_STB) || (op == OP_STW);
                            mem_byte  <= (op == OP_LDB) || (op == OP_STB);
                            mem_addr  <= addr_ext[MEM_AW-1:0];
                            mem_wdata <= (op == OP_STB) ? (in_b & BYTE_MASK) : in_b;
                            ld_rd     <= in_rd;
                        end else if (dec_illegal) begin
                            illegal <= 1'b1;
                        end else if (dec_wr) begin
                            wr_en   <= 1'b1;
                            wr_addr <= in_rd;
                            wr_data <= alu_res;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            wr_en   <= 1'b1;
                            wr_addr <= ld_rd;
                            wr_data <= mem_byte ? (mem_rdata & BYTE_MASK) : mem_rdata;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aap_execute_unit.sv
module tb_aap_execute_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [5:0]  in_rd = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [8:0]  in_imm = '0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        carry;
    logic        illegal;
    logic        mem_req;
    logic        mem_we;
    logic        mem_byte;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [5:0]  sh_op  [9];
    logic [15:0] sh_a   [9];
    logic [15:0] sh_b   [9];
    logic [8:0]  sh_imm [9];
    logic [15:0] sh_exp [9];

    always #5 clock = ~clock;

    aap_execute_unit #(.DATA_W(16), .REG_AW(6), .MEM_AW(16), .IMM_W(9)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .carry(carry), .illegal(illegal),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Offer one instruction at a falling edge; returns at the falling edge
    // after the accepting rising edge, where its results are visible.
    task automatic issue(input logic [5:0] op, input logic [5:0] rd,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [8:0] imm);
        in_op = op; in_rd = rd; in_a = a; in_b = b; in_imm = imm;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({wr_en, illegal, mem_req, mem_we, mem_byte, carry} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=000000", {wr_en, illegal, mem_req, mem_we, mem_byte, carry}); end
        checks++; if ({wr_addr, wr_data, mem_addr, mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", wr_addr, wr_data, mem_addr, mem_wdata); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_add_carry;
        issue(6'd1, 6'd3, 16'hFFFF, 16'h0002, 9'd0);
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL add_wr_en got=%b exp=1", wr_en); end
        checks++; if (wr_addr !== 6'd3) begin failures++; $display("FAIL add_wr_addr got=%0d exp=3", wr_addr); end
        checks++; if (wr_data !== 16'h0001) begin failures++; $display("FAIL add_data got=%h exp=0001", wr_data); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL add_carry got=%b exp=1", carry); end
        issue(6'd20, 6'd4, 16'h0001, 16'h0001, 9'd0);
        checks++; if (wr_data !== 16'h0003) begin failures++; $display("FAIL addc_data got=%h exp=0003", wr_data); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL addc_carry got=%b exp=0", carry); end
    endtask

    task automatic test_sub;
        issue(6'd2, 6'd5, 16'h0001, 16'h0002, 9'd0);
        checks++; if (wr_data !== 16'hFFFF) begin failures++; $display("FAIL sub_data got=%h exp=FFFF", wr_data); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL sub_borrow got=%b exp=1", carry); end
        issue(6'd21, 6'd5, 16'h0005, 16'h0002, 9'd0);
        checks++; if (wr_data !== 16'h0002) begin failures++; $display("FAIL subc_data got=%h exp=0002", wr_data); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL subc_borrow got=%b exp=0", carry); end
        issue(6'd2, 6'd5, 16'h0007, 16'h0007, 9'd0);
        checks++; if (wr_data !== 16'h0000 || carry !== 1'b0) begin
            failures++; $display("FAIL sub_equal got=%h/%b exp=0000/0", wr_data, carry); end
    endtask

    task automatic test_logic;
        issue(6'd3, 6'd1, 16'hF0F0, 16'hFF00, 9'd0);
        checks++; if (wr_data !== 16'hF000) begin failures++; $display("FAIL and_data got=%h exp=F000", wr_data); end
        issue(6'd4, 6'd1, 16'hF0F0, 16'hFF00, 9'd0);
        checks++; if (wr_data !== 16'hFFF0) begin failures++; $display("FAIL or_data got=%h exp=FFF0", wr_data); end
        issue(6'd5, 6'd1, 16'hF0F0, 16'hFF00, 9'd0);
        checks++; if (wr_data !== 16'h0FF0) begin failures++; $display("FAIL xor_data got=%h exp=0FF0", wr_data); end
    endtask

    task automatic test_shifts;
        // Set carry to 1 first; shifts must leave it alone.
        issue(6'd2, 6'd0, 16'h0000, 16'h0001, 9'd0);
        sh_op  = '{6'd6,    6'd6,    6'd8,    6'd8,    6'd7,    6'd7,    6'd13,   6'd12,   6'd14};
        sh_a   = '{16'h8000,16'h8000,16'h8000,16'h8000,16'h0001,16'h00F0,16'h0001,16'h8000,16'hF000};
        sh_b   = '{16'h0020,16'h0004,16'h0010,16'h000F,16'h0010,16'h0004,16'h0000,16'h0000,16'h0000};
        sh_imm = '{9'd0,    9'd0,    9'd0,    9'd0,    9'd0,    9'd0,    9'd3,    9'd511,  9'd4};
        sh_exp = '{16'hFFFF,16'hF800,16'h0000,16'h0001,16'h0000,16'h0F00,16'h0008,16'hFFFF,16'h0F00};
        for (int i = 0; i < 9; i++) begin
            issue(sh_op[i], 6'd2, sh_a[i], sh_b[i], sh_imm[i]);
            checks++; if (wr_en !== 1'b1 || wr_data !== sh_exp[i]) begin
                failures++; $display("FAIL shift_%0d got=%b/%h exp=1/%h", i, wr_en, wr_data, sh_exp[i]); end
        end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL shift_carry_hold got=%b exp=1", carry); end
    endtask

    task automatic test_imm;
        issue(6'd10, 6'd6, 16'hFFFE, 16'h0000, 9'd3);
        checks++; if (wr_data !== 16'h0001 || carry !== 1'b1) begin
            failures++; $display("FAIL addi got=%h/%b exp=0001/1", wr_data, carry); end
        issue(6'd11, 6'd6, 16'h0005, 16'h0000, 9'd6);
        checks++; if (wr_data !== 16'hFFFF || carry !== 1'b1) begin
            failures++; $display("FAIL subi got=%h/%b exp=FFFF/1", wr_data, carry); end
        issue(6'd15, 6'd6, 16'h1234, 16'h5678, 9'h1FF);
        checks++; if (wr_data !== 16'h01FF) begin failures++; $display("FAIL movi got=%h exp=01FF", wr_data); end
        issue(6'd9, 6'd6, 16'hBEEF, 16'h5678, 9'h1FF);
        checks++; if (wr_data !== 16'hBEEF) begin failures++; $display("FAIL mov got=%h exp=BEEF", wr_data); end
    endtask

    task automatic test_illegal_nop;
        issue(6'd40, 6'd1, 16'hFFFF, 16'hFFFF, 9'd0);
        checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_pulse got=%b exp=1", illegal); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL illegal_wr_en got=%b exp=0", wr_en); end
        checks++; if (carry !== 1'b1) begin failures++; $display("FAIL illegal_carry got=%b exp=1", carry); end
        @(negedge clock);
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_one_cycle got=%b exp=0", illegal); end
        issue(6'd0, 6'd1, 16'h0001, 16'h0001, 9'd0);
        checks++; if (wr_en !== 1'b0 || illegal !== 1'b0) begin
            failures++; $display("FAIL nop got=%b/%b exp=0/0", wr_en, illegal); end
    endtask

    task automatic test_store;
        issue(6'd19, 6'd9, 16'h0010, 16'h1234, 9'd0);
        checks++; if ({mem_req, mem_we, mem_byte} !== 3'b110) begin
            failures++; $display("FAIL stw_ctrl got=%b exp=110", {mem_req, mem_we, mem_byte}); end
        checks++; if (mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
            failures++; $display("FAIL stw_bus got=%h/%h exp=0010/1234", mem_addr, mem_wdata); end
        checks++; if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
            failures++; $display("FAIL stw_busy got=%b/%b exp=0/0", in_ready, wr_en); end
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++; if (in_ready !== 1'b1 || mem_req !== 1'b0 || wr_en !== 1'b0) begin
            failures++; $display("FAIL stw_done got=%b/%b/%b exp=1/0/0", in_ready, mem_req, wr_en); end
        issue(6'd18, 6'd9, 16'h0010, 16'hABCD, 9'd1);
        checks++; if (mem_addr !== 16'h0011 || mem_wdata !== 16'h00CD || mem_byte !== 1'b1) begin
            failures++; $display("FAIL stb_bus got=%h/%h/%b exp=0011/00CD/1", mem_addr, mem_wdata, mem_byte); end
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++; if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
            failures++; $display("FAIL stb_done got=%b/%b exp=1/0", in_ready, wr_en); end
    endtask

    task automatic test_load_back_to_back;
        int busy;
        int early_wr;
        busy = 0;
        early_wr = 0;
        issue(6'd16, 6'd7, 16'h0100, 16'h0000, 9'd5);
        checks++; if ({mem_req, mem_we, mem_byte} !== 3'b101 || mem_addr !== 16'h0105) begin
            failures++; $display("FAIL ldb_req got=%b/%h exp=101/0105", {mem_req, mem_we, mem_byte}, mem_addr); end
        for (int i = 0; i < 20; i++) begin
            if (in_ready) break;
            busy++;
            if (wr_en) early_wr++;
            if (busy == 4) begin mem_ack = 1'b1; mem_rdata = 16'hABCD; end
            @(negedge clock);
            mem_ack = 1'b0;
            mem_rdata = 16'h0000;
        end
        checks++; if (busy !== 4) begin failures++; $display("FAIL ldb_busy_cycles got=%0d exp=4", busy); end
        checks++; if (early_wr !== 0) begin failures++; $display("FAIL ldb_early_wr got=%0d exp=0", early_wr); end
        checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd7 || wr_data !== 16'h00CD) begin
            failures++; $display("FAIL ldb_wb got=%b/%0d/%h exp=1/7/00CD", wr_en, wr_addr, wr_data); end
        checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL ldb_release got=%b/%b exp=0/1", mem_req, in_ready); end
        issue(6'd1, 6'd2, 16'h0003, 16'h0004, 9'd0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd2 || wr_data !== 16'h0007 || carry !== 1'b0) begin
            failures++; $display("FAIL b2b_add got=%b/%0d/%h/%b exp=1/2/0007/0", wr_en, wr_addr, wr_data, carry); end
        issue(6'd17, 6'd8, 16'h0200, 16'h0000, 9'd2);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd8 || wr_data !== 16'hBEEF) begin
            failures++; $display("FAIL ldw_wb got=%b/%0d/%h exp=1/8/BEEF", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_idle_ack;
        @(negedge clock);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        @(negedge clock);
        mem_ack = 1'b0;
        checks++; if (wr_en !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL idle_ack got=%b/%b/%b exp=0/0/1", wr_en, mem_req, in_ready); end
    endtask

    task automatic test_reset_mid_op;
        int wr_seen;
        wr_seen = 0;
        issue(6'd17, 6'd5, 16'h0020, 16'h0000, 9'd0);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_async got=%b/%b exp=0/1", mem_req, in_ready); end
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        @(negedge clock);
        reset = 1'b0;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (wr_en) wr_seen++;
        end
        checks++; if (wr_seen !== 0 || wr_data !== 16'h0000) begin
            failures++; $display("FAIL rst_no_wb got=%0d/%h exp=0/0000", wr_seen, wr_data); end
    endtask

    initial begin
        test_reset;
        test_add_carry;
        test_sub;
        test_logic;
        test_shifts;
        test_imm;
        test_illegal_nop;
        test_store;
        test_load_back_to_back;
        test_idle_ack;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
